sqrt_arbiter: RTL

Round-robin arbiter and sequencer that shares one 8-bit iterative integer square-root core between N_REQ requesters.
- Accepts per-requester operands and grants one requester at a time.
- Drives the core's start/operand pins and watches its busy flag.
- Returns the result with a one-cycle done pulse to the owning requester.
- Sits between the requester logic and the single sqrt core instance.

---
 rtl/sqrt_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter/sequencer sharing one 8-bit iterative square-root core among N_REQ requesters.
// Optional build macro SQRT_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module sqrt_arbiter #(
   parameter int N_REQ = 2,
   parameter int IDX_W = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [N_REQ-1:0]     req_i,
   input  logic [8*N_REQ-1:0]   x_i,
   output logic [N_REQ-1:0]     ack_o,
   output logic [N_REQ-1:0]     done_o,
   output logic [7:0]           y_o,
   output logic [IDX_W-1:0]     owner_o,
   output logic                 busy_o,
   output logic                 sq_start_o,
   output logic [7:0]           sq_x_o,
   input  logic                 sq_busy_i,
   input  logic [7:0]           sq_y_i
);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP} state_t;

   state_t             state_q;
   logic [N_REQ-1:0]   ack_q;
   logic [N_REQ-1:0]   done_q;
   logic [7:0]         y_q;
   logic [7:0]         sq_x_q;
   logic [IDX_W-1:0]   owner_q;
   logic               busy_q;
   logic               start_q;

   logic               win_valid;
   logic [IDX_W-1:0]   win_idx;
   logic [7:0]         win_x;
   logic [N_REQ-1:0]   win_oh;
   logic [N_REQ-1:0]   owner_oh;

`ifdef SQRT_ARB_FIXED_PRIO_EN
   always_comb begin
      win_valid = 1'b0;
      win_idx   = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (req_i[k]) begin
            win_valid = 1'b1;
            win_idx   = IDX_W'(k);
         end
      end
   end
`else
   logic [IDX_W-1:0]   ptr_q;
   logic               hi_valid;
   logic [IDX_W-1:0]   hi_idx;

   // Scanning from ptr+1 with wrap: lowest requester above the pointer, else lowest overall.
   always_comb begin
      win_valid = 1'b0;
      win_idx   = '0;
      hi_valid  = 1'b0;
      hi_idx    = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (req_i[k]) begin
            win_valid = 1'b1;
            win_idx   = IDX_W'(k);
            if (IDX_W'(k) > ptr_q) begin
               hi_valid = 1'b1;
               hi_idx   = IDX_W'(k);
            end
         end
      end
      if (hi_valid) begin
         win_idx = hi_idx;
      end
   end
`endif

   always_comb begin
      win_x = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (win_idx == IDX_W'(k)) begin
            win_x = x_i[8*k +: 8];
         end
      end
   end

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
      assign win_oh[gi]   = (win_idx == IDX_W'(gi));
      assign owner_oh[gi] = (owner_q == IDX_W'(gi));
   end

   // ack rises on entry to ISSUE, start one cycle later, done while in RESP.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         ack_q   <= '0;
         done_q  <= '0;
         y_q     <= '0;
         sq_x_q  <= '0;
         owner_q <= '0;
         busy_q  <= 1'b0;
         start_q <= 1'b0;
`ifndef SQRT_ARB_FIXED_PRIO_EN
         ptr_q   <= IDX_W'(N_REQ - 1);
`endif
      end else begin
         ack_q   <= '0;
         done_q  <= '0;
         start_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (win_valid) begin
                  ack_q   <= win_oh;
                  owner_q <= win_idx;
                  sq_x_q  <= win_x;
`ifndef SQRT_ARB_FIXED_PRIO_EN
                  ptr_q   <= win_idx;
`endif
                  busy_q  <= 1'b1;
                  state_q <= ISSUE;
               end
            end
            ISSUE: begin
               start_q <= 1'b1;
               state_q <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               if (sq_busy_i) begin
                  state_q <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (!sq_busy_i) begin
                  y_q     <= sq_y_i;
                  done_q  <= owner_oh;
                  state_q <= RESP;
               end
            end
            RESP: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign ack_o      = ack_q;
   assign done_o     = done_q;
   assign y_o        = y_q;
   assign owner_o    = owner_q;
   assign busy_o     = busy_q;
   assign sq_start_o = start_q;
   assign sq_x_o     = sq_x_q;

endmodule
